// File: rtl/rw_retire_sched.sv
// In-order retire FIFO: holds solver insert locations for a fixed window, then deletes them.
// Optional RW_RETIRE_FLUSH_EN adds a flush input that makes every head due at once.
module rw_retire_sched #(
  parameter int LOC_WIDTH   = 6,
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int TS_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic                         insert_success,
  input  logic [LOC_WIDTH-1:0]         insert_loc,
  output logic                         in_ready,
  input  logic                         del_ready,
  output logic                         valid_delete,
  output logic [LOC_WIDTH-1:0]         del_loc_out,
  output logic [$clog2(DEPTH):0]       occupancy,
`ifdef RW_RETIRE_FLUSH_EN
  input  logic                         flush,
`endif
  output logic                         overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TS_WIDTH-1:0] LP_DUE =
    TS_WIDTH'(HOLD_CYCLES - 1);

  logic [LOC_WIDTH-1:0] r_loc_mem [DEPTH];
  logic [TS_WIDTH-1:0]  r_ts_mem  [DEPTH];

  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [CW-1:0]        r_count;
  logic [TS_WIDTH-1:0]  r_now;
  logic                 r_valid;
  logic [LOC_WIDTH-1:0] r_loc;
  logic                 r_ovf;

  logic                 w_stall;
  logic                 w_consume;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_force;
  logic [TS_WIDTH-1:0]  w_age;
  logic                 w_due;
  logic                 w_pop;
  logic                 w_push_req;
  logic                 w_push;
  logic                 w_drop;
  logic [TS_WIDTH-1:0]  w_now_nxt;

`ifdef RW_RETIRE_FLUSH_EN
  assign w_force = flush;
`else
  assign w_force = 1'b0;
`endif

  assign w_stall    = r_valid & ~del_ready;
  assign w_consume  = ~w_stall;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_age      = r_now - r_ts_mem[r_rd];
  assign w_due      = ~w_empty & (w_force | (w_age >= LP_DUE));
  assign w_pop      = w_consume & w_due;
  assign w_push_req = valid_in & insert_success;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_now_nxt  = w_stall ? r_now : r_now + TS_WIDTH'(1);

  // Entries are stamped with the time the counter holds after the
  // capture edge, so the retire lands exactly HOLD_CYCLES edges later.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_loc_mem[r_wr] <= insert_loc;
      r_ts_mem[r_wr]  <= w_now_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_now   <= '0;
      r_valid <= 1'b0;
      r_loc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_now <= w_now_nxt;
      if (w_push)
        r_wr <= r_wr + AW'(1);
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_valid <= 1'b1;
        r_loc   <= r_loc_mem[r_rd];
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
      if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  assign in_ready     = ~w_full;
  assign valid_delete = r_valid;
  assign del_loc_out  = r_loc;
  assign occupancy    = r_count;
  assign overflow_err = r_ovf;

endmodule
